// File: rtl/kpd_pkg.sv
// Keypad scanner shared types: scan and debounce state encodings, key index to hex map.
package kpd_pkg;

  typedef enum logic [2:0] {
    SCAN_ROW0 = 3'd0,
    SCAN_ROW1 = 3'd1,
    SCAN_ROW2 = 3'd2,
    SCAN_ROW3 = 3'd3,
    SCAN_EVAL = 3'd4
  } scan_state_t;

  typedef enum logic [1:0] {
    DB_RELEASED   = 2'd0,
    DB_PRESS_DB   = 2'd1,
    DB_PRESSED    = 2'd2,
    DB_RELEASE_DB = 2'd3
  } db_state_t;

  // Entry [row*4+col]; rows read 1,2,3,A / 4,5,6,B / 7,8,9,C / E,0,F,D.
  localparam logic [15:0][3:0] KPD_HEX = {
    4'hD, 4'hF, 4'h0, 4'hE,
    4'hC, 4'h9, 4'h8, 4'h7,
    4'hB, 4'h6, 4'h5, 4'h4,
    4'hA, 4'h3, 4'h2, 4'h1
  };

  localparam logic [3:0] KPD_CLR_CODE = 4'hE;

endpackage

// File: rtl/kpd_if.sv
// Key event bus: valid/ready event handshake plus held, overrun and accumulator status.
interface kpd_if;
  logic        key_valid;
  logic        key_ready;
  logic [3:0]  key_code;
  logic        key_held;
  logic        overrun;
  logic [15:0] accum;

  modport master (
    output key_valid, key_code, key_held, overrun, accum,
    input  key_ready
  );

  modport slave (
    input  key_valid, key_code, key_held, overrun, accum,
    output key_ready
  );
endinterface

// File: rtl/kpd_sync2.sv
// 4-bit two-flop synchronizer for the asynchronous column inputs; resets to idle-high.
module kpd_sync2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] i_d,
  output logic [3:0] o_q
);
  logic [3:0] r_s1;
  logic [3:0] r_s2;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1 <= 4'hF;
      r_s2 <= 4'hF;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
    end
  end

  assign o_q = r_s2;
endmodule

// File: rtl/kpd_scan.sv
// 4x4 keypad scanner: row strobe, whole-scan debounce, one-entry key event buffer.
// Define KPD_ACCUM_EN to build the BCD entry accumulator on accum; otherwise accum is zero.
module kpd_scan
  import kpd_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter int DB_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst,
  output logic [3:0] rows,
  input  logic [3:0] cols,
  kpd_if.master      kpd
);
  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DB_W  = $clog2(DB_SCANS + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DB_SCANS - 1);

  logic [3:0] w_cols_s;

  kpd_sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .i_d (cols),
    .o_q (w_cols_s)
  );

  scan_state_t      r_scan, w_scan_nxt;
  logic [DIV_W-1:0] r_div, w_div_nxt;
  logic [3:0]       w_rows;
  logic [1:0]       w_row;
  logic             w_last;
  logic [15:0]      r_samp;

  always_comb begin
    w_scan_nxt = r_scan;
    w_rows     = 4'b1111;
    w_row      = 2'd0;
    w_last     = (r_div == DIV_LAST);
    unique case (r_scan)
      SCAN_ROW0: begin w_rows = 4'b1110; w_row = 2'd0; if (w_last) w_scan_nxt = SCAN_ROW1; end
      SCAN_ROW1: begin w_rows = 4'b1101; w_row = 2'd1; if (w_last) w_scan_nxt = SCAN_ROW2; end
      SCAN_ROW2: begin w_rows = 4'b1011; w_row = 2'd2; if (w_last) w_scan_nxt = SCAN_ROW3; end
      SCAN_ROW3: begin w_rows = 4'b0111; w_row = 2'd3; if (w_last) w_scan_nxt = SCAN_EVAL; end
      SCAN_EVAL: w_scan_nxt = SCAN_ROW0;
      default:   w_scan_nxt = SCAN_ROW0;
    endcase
    w_div_nxt = (w_last || r_scan == SCAN_EVAL) ? '0 : r_div + 1'b1;
  end

  // r_samp bit row*4+col is set when that key read as pressed on the last dwell cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_scan <= SCAN_ROW0;
      r_div  <= '0;
      r_samp <= '0;
    end else begin
      r_scan <= w_scan_nxt;
      r_div  <= w_div_nxt;
      if (w_last && r_scan != SCAN_EVAL) r_samp[{w_row, 2'b00} +: 4] <= ~w_cols_s;
    end
  end

  assign rows = w_rows;

  logic [1:0] w_nkeys;
  logic [3:0] w_idx;
  logic       w_single;

  always_comb begin
    w_nkeys = 2'd0;
    w_idx   = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (r_samp[i]) begin
        w_idx = 4'(i);
        if (w_nkeys != 2'd2) w_nkeys = w_nkeys + 2'd1;
      end
    end
    w_single = (w_nkeys == 2'd1);
  end

  db_state_t       r_db, w_db_nxt;
  logic [DB_W-1:0] r_cnt, w_cnt_nxt;
  logic [3:0]      r_key, w_key_nxt;
  logic            w_evt;
  logic            w_match;
  logic [3:0]      w_evt_code;

  always_comb begin
    w_db_nxt   = r_db;
    w_cnt_nxt  = r_cnt;
    w_key_nxt  = r_key;
    w_evt      = 1'b0;
    w_match    = w_single && (w_idx == r_key);
    if (r_scan == SCAN_EVAL) begin
      unique case (r_db)
        DB_RELEASED: if (w_single) begin
          w_key_nxt = w_idx;
          w_cnt_nxt = DB_W'(1);
          if (DB_SCANS <= 1) begin w_db_nxt = DB_PRESSED; w_evt = 1'b1; w_cnt_nxt = '0; end
          else               w_db_nxt = DB_PRESS_DB;
        end
        DB_PRESS_DB: begin
          if (!w_single) begin
            w_db_nxt  = DB_RELEASED;
            w_cnt_nxt = '0;
          end else if (!w_match) begin
            w_key_nxt = w_idx;
            w_cnt_nxt = DB_W'(1);
          end else if (r_cnt == DB_LAST) begin
            w_db_nxt  = DB_PRESSED;
            w_cnt_nxt = '0;
            w_evt     = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        DB_PRESSED: if (!w_match) begin
          w_cnt_nxt = DB_W'(1);
          if (DB_SCANS <= 1) begin w_db_nxt = DB_RELEASED; w_cnt_nxt = '0; end
          else               w_db_nxt = DB_RELEASE_DB;
        end
        DB_RELEASE_DB: begin
          if (w_match) begin
            w_db_nxt  = DB_PRESSED;
            w_cnt_nxt = '0;
          end else if (r_cnt == DB_LAST) begin
            w_db_nxt  = DB_RELEASED;
            w_cnt_nxt = '0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        default: begin
          w_db_nxt  = DB_RELEASED;
          w_cnt_nxt = '0;
        end
      endcase
    end
    w_evt_code = KPD_HEX[w_key_nxt];
  end

  logic       r_vld;
  logic [3:0] r_code;
  logic       r_ovr;
  logic       w_pop;

  assign w_pop = r_vld && kpd.key_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_db   <= DB_RELEASED;
      r_cnt  <= '0;
      r_key  <= 4'd0;
      r_vld  <= 1'b0;
      r_code <= 4'd0;
      r_ovr  <= 1'b0;
    end else begin
      r_db  <= w_db_nxt;
      r_cnt <= w_cnt_nxt;
      r_key <= w_key_nxt;
      // A pop in the same cycle frees the slot, so the new event is not an overrun.
      if (w_evt && (!r_vld || w_pop)) begin
        r_vld  <= 1'b1;
        r_code <= w_evt_code;
      end else if (w_pop) begin
        r_vld <= 1'b0;
      end
      if (w_evt && r_vld && !w_pop) r_ovr <= 1'b1;
    end
  end

  assign kpd.key_valid = r_vld;
  assign kpd.key_code  = r_code;
  assign kpd.overrun   = r_ovr;
  assign kpd.key_held  = (r_db == DB_PRESSED) || (r_db == DB_RELEASE_DB);

`ifdef KPD_ACCUM_EN
  logic [15:0] r_accum;

  // Dropped events still feed the accumulator: it tracks keys entered, not keys consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_accum <= 16'h0000;
    end else if (w_evt) begin
      if (w_evt_code <= 4'h9)               r_accum <= {r_accum[11:0], w_evt_code};
      else if (w_evt_code == KPD_CLR_CODE)  r_accum <= 16'h0000;
    end
  end

  assign kpd.accum = r_accum;
`else
  assign kpd.accum = 16'h0000;
`endif

endmodule

// File: tb/tb_kpd_scan.sv
// Self-checking bench for kpd_scan: scan-aligned keypad stimulus against a run-length debounce model.
module tb_kpd_scan;
  localparam int SCAN_DIV = 4;
  localparam int DB       = 2;
  localparam int PERIOD   = 4 * SCAN_DIV + 1;
`ifdef KPD_ACCUM_EN
  localparam logic [15:0] ACC_0123 = 16'h0123;
`else
  localparam logic [15:0] ACC_0123 = 16'h0000;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  rows;
  logic [3:0]  cols;
  logic [15:0] keys_dn = '0;
  int          cyc = 0;
  int          errs = 0;
  int          checks = 0;

  bit          m_down, m_valid, m_ovr, m_evt;
  int          m_key, m_run_key, m_run, m_miss;
  logic [3:0]  m_code;
  logic [15:0] m_acc;
  logic [63:0] hexmap = 64'hDF0E_C987_B654_A321;

  kpd_if u_if ();

  kpd_scan #(.SCAN_DIV(SCAN_DIV), .DB_SCANS(DB)) dut (
    .clk  (clk),
    .rst  (rst),
    .rows (rows),
    .cols (cols),
    .kpd  (u_if)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  // Passive keypad matrix: a held key pulls its column low while its row is driven low.
  always_comb begin
    cols = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!rows[r] && keys_dn[r*4+c]) cols[c] = 1'b0;
  end

  function automatic logic [15:0] exp_accum();
`ifdef KPD_ACCUM_EN
    return m_acc;
`else
    return 16'h0000;
`endif
  endfunction

  function automatic logic [22:0] got_v();
    return {u_if.key_held, u_if.key_valid, u_if.key_code, u_if.overrun, u_if.accum};
  endfunction

  function automatic logic [22:0] exp_v();
    return {m_down, m_valid, m_code, m_ovr, exp_accum()};
  endfunction

  task automatic model_reset();
    m_down = 1'b0; m_valid = 1'b0; m_ovr = 1'b0; m_evt = 1'b0;
    m_key = 0; m_run_key = -1; m_run = 0; m_miss = 0;
    m_code = 4'h0; m_acc = 16'h0000;
  endtask

  task automatic model_scan(input logic [15:0] mask, input bit ready);
    int res;
    logic [3:0] hx;
    res = -1;
    if ($countones(mask) == 1)
      for (int i = 0; i < 16; i++) if (mask[i]) res = i;
    if (ready) m_valid = 1'b0;
    m_evt = 1'b0;
    if (!m_down) begin
      if (res >= 0 && res == m_run_key) m_run++;
      else begin m_run_key = res; m_run = (res >= 0) ? 1 : 0; end
      if (m_run >= DB) begin m_down = 1'b1; m_key = res; m_evt = 1'b1; m_run = 0; end
    end else begin
      m_miss = (res == m_key) ? 0 : m_miss + 1;
      if (m_miss >= DB) begin m_down = 1'b0; m_miss = 0; m_run_key = -1; end
    end
    if (m_evt) begin
      hx = hexmap[m_key*4 +: 4];
      if (m_valid) m_ovr = 1'b1;
      else begin m_valid = 1'b1; m_code = hx; end
      if (hx <= 4'h9) m_acc = {m_acc[11:0], hx};
      else if (hx == 4'hE) m_acc = 16'h0000;
    end
  endtask

  // Holds a key pattern for one full scan and returns one cycle after that scan's EVAL.
  task automatic run_scan(input logic [15:0] mask, input bit ready);
    keys_dn = mask;
    u_if.key_ready = ready;
    model_scan(mask, ready);
    for (int n = 0; n < PERIOD; n++) begin
      @(posedge clk); #1;
      if (cyc % PERIOD == 0) break;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    keys_dn = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    keys_dn = '0;
    u_if.key_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (rows !== 4'b1110) begin errs++; $display("FAIL reset_rows: got %b want 1110", rows); end
    checks++;
    if (got_v() !== 23'h0) begin errs++; $display("FAIL reset_outputs: got %h want 0", got_v()); end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_scan_seq();
    logic [3:0] one;
    logic [3:0] want;
    int p;
    do_reset();
    one = 4'b0001;
    for (int i = 0; i < 3 * PERIOD; i++) begin
      p = i % PERIOD;
      want = (p < 4 * SCAN_DIV) ? ~(one << (p / SCAN_DIV)) : 4'b1111;
      checks++;
      if (rows !== want) begin errs++; $display("FAIL scan_rows cycle %0d: got %b want %b", i, rows, want); end
      checks++;
      if (u_if.key_valid !== 1'b0) begin errs++; $display("FAIL scan_idle_valid cycle %0d: got %b want 0", i, u_if.key_valid); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_single_key();
    logic [15:0] seq [6];
    int pulses;
    logic [3:0] last_code;
    seq = '{16'h0040, 16'h0040, 16'h0040, 16'h0000, 16'h0000, 16'h0000};
    do_reset();
    pulses = 0;
    last_code = 4'h0;
    for (int i = 0; i < 6; i++) begin
      run_scan(seq[i], 1'b1);
      if (u_if.key_valid === 1'b1) begin pulses++; last_code = u_if.key_code; end
      checks++;
      if (got_v() !== exp_v()) begin errs++; $display("FAIL single_key scan %0d: got %h want %h", i, got_v(), exp_v()); end
    end
    checks++;
    if (pulses !== 1 || last_code !== 4'h6) begin
      errs++; $display("FAIL single_key_events: got %0d events code %h want 1 event code 6", pulses, last_code);
    end
  endtask

  task automatic test_short_press();
    logic [15:0] seq [5];
    int pulses;
    seq = '{16'h0020, 16'h0000, 16'h0000, 16'h0020, 16'h0000};
    do_reset();
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      run_scan(seq[i], 1'b1);
      if (u_if.key_valid === 1'b1) pulses++;
      checks++;
      if (got_v() !== exp_v()) begin errs++; $display("FAIL short_press scan %0d: got %h want %h", i, got_v(), exp_v()); end
    end
    checks++;
    if (pulses !== 0) begin errs++; $display("FAIL short_press_events: got %0d want 0", pulses); end
  endtask

  task automatic test_overrun();
    logic [15:0] seq [6];
    seq = '{16'h0001, 16'h0001, 16'h0000, 16'h0000, 16'h0002, 16'h0002};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      run_scan(seq[i], 1'b0);
      checks++;
      if (got_v() !== exp_v()) begin errs++; $display("FAIL overrun scan %0d: got %h want %h", i, got_v(), exp_v()); end
    end
    checks++;
    if ({u_if.key_valid, u_if.key_code, u_if.overrun} !== {1'b1, 4'h1, 1'b1}) begin
      errs++; $display("FAIL overrun_hold: got vld=%b code=%h ovr=%b want vld=1 code=1 ovr=1",
                       u_if.key_valid, u_if.key_code, u_if.overrun);
    end
    u_if.key_ready = 1'b1;
    @(posedge clk); #1;
    m_valid = 1'b0;
    checks++;
    if ({u_if.key_valid, u_if.overrun} !== 2'b01) begin
      errs++; $display("FAIL overrun_pop: got vld=%b ovr=%b want vld=0 ovr=1", u_if.key_valid, u_if.overrun);
    end
  endtask

  task automatic test_multi();
    logic [15:0] seq [11];
    int ev3_at;
    seq = '{16'h0110, 16'h0110, 16'h0110, 16'h0040, 16'h0040,
            16'h0004, 16'h0004, 16'h0004, 16'h0004, 16'h0000, 16'h0000};
    do_reset();
    ev3_at = -1;
    for (int i = 0; i < 11; i++) begin
      run_scan(seq[i], 1'b1);
      if (u_if.key_valid === 1'b1 && u_if.key_code === 4'h3 && ev3_at < 0) ev3_at = i;
      checks++;
      if (got_v() !== exp_v()) begin errs++; $display("FAIL multi scan %0d: got %h want %h", i, got_v(), exp_v()); end
    end
    checks++;
    if (ev3_at !== 8) begin errs++; $display("FAIL multi_key3_timing: got scan %0d want scan 8", ev3_at); end
  endtask

  task automatic test_accum();
    logic [15:0] seq [16];
    seq = '{16'h0001, 16'h0001, 16'h0000, 16'h0000, 16'h0002, 16'h0002, 16'h0000, 16'h0000,
            16'h0004, 16'h0004, 16'h0000, 16'h0000, 16'h1000, 16'h1000, 16'h0000, 16'h0000};
    do_reset();
    for (int i = 0; i < 16; i++) begin
      run_scan(seq[i], 1'b1);
      checks++;
      if (got_v() !== exp_v()) begin errs++; $display("FAIL accum scan %0d: got %h want %h", i, got_v(), exp_v()); end
      if (i == 11) begin
        checks++;
        if (u_if.accum !== ACC_0123) begin errs++; $display("FAIL accum_123: got %h want %h", u_if.accum, ACC_0123); end
      end
    end
    checks++;
    if (u_if.accum !== 16'h0000) begin errs++; $display("FAIL accum_clear: got %h want 0000", u_if.accum); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] seq [9];
    seq = '{16'h0001, 16'h0001, 16'h0000, 16'h0000, 16'h0002, 16'h0002, 16'h0000, 16'h0000, 16'h0020};
    do_reset();
    for (int i = 0; i < 9; i++) begin
      run_scan(seq[i], 1'b0);
      checks++;
      if (got_v() !== exp_v()) begin errs++; $display("FAIL reset_mid scan %0d: got %h want %h", i, got_v(), exp_v()); end
    end
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({rows, got_v()} !== {4'b1110, 23'h0}) begin
      errs++; $display("FAIL reset_mid_outputs: got rows=%b out=%h want rows=1110 out=0", rows, got_v());
    end
    rst = 1'b0;
    model_reset();
    run_scan(16'h0020, 1'b1);
    checks++;
    if (got_v() !== exp_v()) begin errs++; $display("FAIL reset_mid_restart: got %h want %h", got_v(), exp_v()); end
  endtask

  task automatic test_random();
    int kind;
    int hold;
    bit rdy;
    logic [15:0] mask;
    do_reset();
    for (int s = 0; s < 40; s++) begin
      kind = $urandom_range(0, 3);
      hold = $urandom_range(1, 4);
      rdy  = ($urandom_range(0, 3) != 0);
      mask = '0;
      if (kind == 1 || kind == 2) mask[$urandom_range(0, 15)] = 1'b1;
      else if (kind == 3) begin
        mask[$urandom_range(0, 15)] = 1'b1;
        mask[$urandom_range(0, 15)] = 1'b1;
      end
      for (int h = 0; h < hold; h++) begin
        run_scan(mask, rdy);
        checks++;
        if (got_v() !== exp_v()) begin
          errs++; $display("FAIL random seg %0d scan %0d mask %h: got %h want %h", s, h, mask, got_v(), exp_v());
        end
      end
    end
  endtask

  initial begin
    u_if.key_ready = 1'b1;
    model_reset();
    test_reset();
    test_scan_seq();
    test_single_key();
    test_short_press();
    test_overrun();
    test_multi();
    test_accum();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/kpd_scan.md
KPD_SCAN -- requirements
Module: kpd_scan

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000; clk cycles each keypad row is driven.
REQ-002 SHALL have parameter DB_SCANS, default 4; consecutive identical full scans required to accept a press or a release.
REQ-003 SHALL have port clk, input, 1; the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-005 SHALL have port rows, output, 4; active-low row drive to the 4x4 keypad.
REQ-006 SHALL have port cols, input, 4; active-low column sense, asynchronous, externally pulled up.
REQ-007 SHALL have port key_valid, output, 1; a buffered key event is available.
REQ-008 SHALL have port key_ready, input, 1; the consumer accepts the event.
REQ-009 SHALL have port key_code, output, 4; hex value of the buffered key.
REQ-010 SHALL have port key_held, output, 1; a debounced key is currently down.
REQ-011 SHALL have port overrun, output, 1; sticky flag for a dropped press.
REQ-012 SHALL have port accum, output, 16; BCD entry value for the seven-segment path (see Configuration).

Function
REQ-013 SHALL pass cols through a 2-flop synchronizer before any use.
REQ-014 Scan FSM SHALL cycle ROW0->ROW1->ROW2->ROW3->EVAL->ROW0; ROWn dwells SCAN_DIV cycles driving rows bit n low and all others high; EVAL lasts 1 cycle with rows=4'b1111; scan period = 4*SCAN_DIV+1 cycles.
REQ-015 SHALL sample the synchronized cols on the last dwell cycle of each row.
REQ-016 Key index SHALL be row*4+col; the hex mapping is row0 1,2,3,A / row1 4,5,6,B / row2 7,8,9,C / row3 E,0,F,D.
REQ-017 Scan result at EVAL SHALL be exactly one key (its index), NONE (no key), or MULTI (two or more keys); MULTI is treated as NONE.
REQ-018 Debounce FSM states SHALL be RELEASED, PRESS_DB, PRESSED and RELEASE_DB; it updates only in EVAL.
REQ-019 RELEASED->PRESS_DB on single key K; PRESS_DB counts matching scans; a different key restarts the count with the new key; NONE returns to RELEASED; DB_SCANS matches enters PRESSED.
REQ-020 On entering PRESSED: key_held=1 and a press event is raised in the cycle after EVAL.
REQ-021 PRESSED->RELEASE_DB on any result other than K; DB_SCANS consecutive non-K scans enter RELEASED with key_held=0; one K scan returns to PRESSED without raising an event.
REQ-022 A single-entry buffer SHALL hold a press event: key_valid=1 with key_code stable until a cycle with key_valid&&key_ready, which clears key_valid in the next cycle.
REQ-023 A press event while the buffer is full SHALL be dropped and set overrun; a pop in the same cycle as a new event SHALL accept the new key without setting overrun.
REQ-024 overrun SHALL clear only on rst.

Reset
REQ-025 While rst=1 in a clock cycle: the scan FSM goes to ROW0 with a zero dwell counter, rows=4'b1110, the debounce FSM goes to RELEASED with a zero counter, key_valid=0, key_code=0, key_held=0, overrun=0, accum=0 and the synchronizer is cleared to 4'b1111.
REQ-026 Reset during any scan or debounce state SHALL discard a partial debounce and any pending buffered key.

Configuration
REQ-027 With KPD_ACCUM_EN defined, each accepted key 0-9 SHALL shift accum<={accum[11:0],code}; key E SHALL clear accum; other keys leave it unchanged; the update happens in the same cycle the event enters the buffer, including events dropped by REQ-023.
REQ-028 Without KPD_ACCUM_EN, accum SHALL be constant 16'h0000 and have no register.

Structure
REQ-029 Package kpd_pkg SHALL hold the scan-state and debounce-state enums, the 16-entry index-to-hex table and the E clear code.
REQ-030 Sub-module kpd_sync2 (a 4-bit 2-flop synchronizer with reset) SHALL be used; all other logic is flat.

Verification (SCAN_DIV=4, DB_SCANS=2, key_ready=1 unless stated)
REQ-031 Reset, then run idle for 3 scan periods -> rows sequence 1110,1101,1011,0111 with 4 cycles each, then 1111 for 1 cycle; key_valid stays 0.
REQ-032 Hold row1/col2 for 3 scans -> one key_valid pulse with key_code=6, key_held=1; release it -> key_held=0 after 2 NONE scans and no second event.
REQ-033 Press key 5 for 1 scan then release it -> no event, debounce FSM returns to RELEASED.
REQ-034 With key_ready=0, press 1 and release it, then press 2 -> key_code stays 1 and overrun=1; raising key_ready then clears key_valid.
REQ-035 Press keys 4 and 7 together -> MULTI gives no event; pressing 3 during RELEASE_DB from a prior key -> event for 3 only after a full release plus 2 scans.
REQ-036 With KPD_ACCUM_EN, press 1,2,3 -> accum=16'h0123; then press row3/col0 (E) -> accum=16'h0000; asserting rst mid-PRESS_DB -> all outputs at reset values the next cycle.
